// File: rtl/regbank_write_arbiter.sv
// Merges ALU and load writebacks into the register bank's single write port.
// Each source has a small FIFO, a round-robin arbiter drains them, and read-after-write hazards are flagged.
module regbank_write_arbiter #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             AluValid,
    output logic             AluReady,
    input  logic [4:0]       AluAddr,
    input  logic [WIDTH-1:0] AluData,
    input  logic             MemValid,
    output logic             MemReady,
    input  logic [4:0]       MemAddr,
    input  logic [WIDTH-1:0] MemData,
    input  logic [4:0]       RdAddrA,
    input  logic [4:0]       RdAddrB,
    output logic             HazardA,
    output logic             HazardB,
    output logic             WrEn,
    output logic [4:0]       WrAddr,
    output logic [WIDTH-1:0] WrData,
    output logic             Busy
);

    localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef enum logic {PRIO_ALU, PRIO_MEM} rrState_t;

    rrState_t rrState;

    logic [4:0]       aluAddrQ [DEPTH];
    logic [WIDTH-1:0] aluDataQ [DEPTH];
    logic [DEPTH-1:0] aluOcc;
    logic [PTRW-1:0]  aluWrPtr, aluRdPtr;

    logic [4:0]       memAddrQ [DEPTH];
    logic [WIDTH-1:0] memDataQ [DEPTH];
    logic [DEPTH-1:0] memOcc;
    logic [PTRW-1:0]  memWrPtr, memRdPtr;

    logic aluFull, aluEmpty, memFull, memEmpty;
    logic aluPush, memPush, aluGrant, memGrant;

    assign aluFull  = &aluOcc;
    assign aluEmpty = ~|aluOcc;
    assign memFull  = &memOcc;
    assign memEmpty = ~|memOcc;

    assign AluReady = ~aluFull;
    assign MemReady = ~memFull;

    // Writes to the zero register complete the handshake but are dropped here.
    assign aluPush = AluValid & ~aluFull & (AluAddr != ZERO_REG);
    assign memPush = MemValid & ~memFull & (MemAddr != ZERO_REG);

    assign aluGrant = ~aluEmpty & (memEmpty | (rrState == PRIO_ALU));
    assign memGrant = ~memEmpty & ~aluGrant;

    assign Busy = ~aluEmpty | ~memEmpty | WrEn;

    always_ff @(posedge Clk) begin
        if (aluPush) begin
            aluAddrQ[aluWrPtr] <= AluAddr;
            aluDataQ[aluWrPtr] <= AluData;
        end
        if (memPush) begin
            memAddrQ[memWrPtr] <= MemAddr;
            memDataQ[memWrPtr] <= MemData;
        end
    end

    // Per-slot occupancy bits double as the FIFO count and as the hazard mask.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            aluOcc   <= '0;
            aluWrPtr <= '0;
            aluRdPtr <= '0;
            memOcc   <= '0;
            memWrPtr <= '0;
            memRdPtr <= '0;
        end else begin
            if (aluPush) begin
                aluOcc[aluWrPtr] <= 1'b1;
                aluWrPtr         <= aluWrPtr + PTRW'(1);
            end
            if (aluGrant) begin
                aluOcc[aluRdPtr] <= 1'b0;
                aluRdPtr         <= aluRdPtr + PTRW'(1);
            end
            if (memPush) begin
                memOcc[memWrPtr] <= 1'b1;
                memWrPtr         <= memWrPtr + PTRW'(1);
            end
            if (memGrant) begin
                memOcc[memRdPtr] <= 1'b0;
                memRdPtr         <= memRdPtr + PTRW'(1);
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rrState <= PRIO_ALU;
            WrEn    <= 1'b0;
            WrAddr  <= ZERO_REG;
            WrData  <= '0;
        end else begin
            WrEn <= aluGrant | memGrant;
            if (aluGrant) begin
                WrAddr  <= aluAddrQ[aluRdPtr];
                WrData  <= aluDataQ[aluRdPtr];
                rrState <= PRIO_MEM;
            end else if (memGrant) begin
                WrAddr  <= memAddrQ[memRdPtr];
                WrData  <= memDataQ[memRdPtr];
                rrState <= PRIO_ALU;
            end
        end
    end

    // A hazard is any queued entry or the write in flight targeting the read address.
    always_comb begin
        logic matchA, matchB;
        matchA = WrEn & (WrAddr == RdAddrA);
        matchB = WrEn & (WrAddr == RdAddrB);
        for (int i = 0; i < DEPTH; i++) begin
            if (aluOcc[i] && (aluAddrQ[i] == RdAddrA)) matchA = 1'b1;
            if (aluOcc[i] && (aluAddrQ[i] == RdAddrB)) matchB = 1'b1;
            if (memOcc[i] && (memAddrQ[i] == RdAddrA)) matchA = 1'b1;
            if (memOcc[i] && (memAddrQ[i] == RdAddrB)) matchB = 1'b1;
        end
        HazardA = matchA & (RdAddrA != ZERO_REG);
        HazardB = matchB & (RdAddrB != ZERO_REG);
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed testbench for regbank_write_arbiter with hand-computed expectations.
module tb_regbank_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        AluValid, MemValid;
    logic        AluReady, MemReady;
    logic [4:0]  AluAddr, MemAddr, RdAddrA, RdAddrB;
    logic [63:0] AluData, MemData;
    logic        HazardA, HazardB, WrEn, Busy;
    logic [4:0]  WrAddr;
    logic [63:0] WrData;

    int checkCount = 0;
    int errorCount = 0;

    regbank_write_arbiter #(.WIDTH(64), .DEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluReady(AluReady), .AluAddr(AluAddr), .AluData(AluData),
        .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemData(MemData),
        .RdAddrA(RdAddrA), .RdAddrB(RdAddrB), .HazardA(HazardA), .HazardB(HazardB),
        .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic aluV, input logic [4:0] aluA, input logic [63:0] aluD,
                                 input logic memV, input logic [4:0] memA, input logic [63:0] memD);
        AluValid = aluV; AluAddr = aluA; AluData = aluD;
        MemValid = memV; MemAddr = memA; MemData = memD;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic resetPulse();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    logic [63:0] aluExp[$];
    logic [63:0] memExp[$];
    logic [63:0] expData;
    int aluAcc, memAcc, wrCount;

    initial begin
        Reset = 1'b1;
        RdAddrA = 5'd0;
        RdAddrB = 5'd0;
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #3;
        $display("[TB] reset state");
        checkOutput("rst_alu_ready", AluReady, 1);
        checkOutput("rst_mem_ready", MemReady, 1);
        checkOutput("rst_wren", WrEn, 0);
        checkOutput("rst_wraddr", WrAddr, 31);
        checkOutput("rst_wrdata", WrData, 0);
        checkOutput("rst_busy", Busy, 0);
        checkOutput("rst_hazA", HazardA, 0);
        tick();
        Reset = 1'b0;

        $display("[TB] single ALU write");
        applyStimulus(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'h0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        checkOutput("t1_wren_early", WrEn, 0);
        checkOutput("t1_busy", Busy, 1);
        tick();
        checkOutput("t1_wren", WrEn, 1);
        checkOutput("t1_wraddr", WrAddr, 5);
        checkOutput("t1_wrdata", WrData, 64'h1234);
        tick();
        checkOutput("t1_wren_off", WrEn, 0);
        checkOutput("t1_wraddr_hold", WrAddr, 5);
        checkOutput("t1_busy_off", Busy, 0);

        $display("[TB] both sources streaming");
        resetPulse();
        aluAcc = 0; memAcc = 0; wrCount = 0;
        for (int c = 0; c < 11; c++) begin
            if (c < 8) applyStimulus(1'b1, 5'd1, 64'hA000 + 64'(c), 1'b1, 5'd2, 64'hB000 + 64'(c));
            else       applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
            if (c >= 2 && c < 8) begin
                checkOutput($sformatf("t3_alu_ready_c%0d", c), AluReady, (c % 2 == 0) ? 1 : 0);
                checkOutput($sformatf("t3_mem_ready_c%0d", c), MemReady, (c % 2 == 1) ? 1 : 0);
            end
            if (AluValid && AluReady) begin aluExp.push_back(AluData); aluAcc++; end
            if (MemValid && MemReady) begin memExp.push_back(MemData); memAcc++; end
            tick();
            checkOutput($sformatf("t2_wren_c%0d", c), WrEn, (c >= 1) ? 1 : 0);
            if (c >= 1) checkOutput($sformatf("t2_wraddr_c%0d", c), WrAddr, (c % 2 == 1) ? 1 : 2);
            if (WrEn) begin
                wrCount++;
                if (WrAddr == 5'd1 && aluExp.size() > 0)      expData = aluExp.pop_front();
                else if (WrAddr == 5'd2 && memExp.size() > 0) expData = memExp.pop_front();
                else                                          expData = 64'hDEAD_DEAD;
                checkOutput($sformatf("t3_wrdata_c%0d", c), WrData, expData);
            end
        end
        tick();
        checkOutput("t3_alu_acc", aluAcc, 5);
        checkOutput("t3_mem_acc", memAcc, 5);
        checkOutput("t3_wr_count", wrCount, 10);
        checkOutput("t3_alu_left", aluExp.size(), 0);
        checkOutput("t3_mem_left", memExp.size(), 0);
        checkOutput("t3_wren_done", WrEn, 0);
        checkOutput("t3_busy_done", Busy, 0);

        $display("[TB] zero register write");
        RdAddrA = 5'd31;
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd31, 64'h5555);
        checkOutput("t4_mem_ready", MemReady, 1);
        tick();
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        checkOutput("t4_busy", Busy, 0);
        checkOutput("t4_hazA", HazardA, 0);
        checkOutput("t4_wren", WrEn, 0);
        tick();
        checkOutput("t4_wren_late", WrEn, 0);

        $display("[TB] hazard tracking");
        RdAddrA = 5'd7;
        RdAddrB = 5'd8;
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b1, 5'd7, 64'h7777);
        checkOutput("t5_hazA_prepush", HazardA, 0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        checkOutput("t5_hazA_queued", HazardA, 1);
        checkOutput("t5_hazB_queued", HazardB, 0);
        tick();
        checkOutput("t5_wren", WrEn, 1);
        checkOutput("t5_wraddr", WrAddr, 7);
        checkOutput("t5_wrdata", WrData, 64'h7777);
        checkOutput("t5_hazA_inflight", HazardA, 1);
        checkOutput("t5_hazB_inflight", HazardB, 0);
        tick();
        checkOutput("t5_hazA_after", HazardA, 0);

        $display("[TB] reset with queued entries");
        RdAddrA = 5'd6;
        RdAddrB = 5'd0;
        applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
        tick();
        applyStimulus(1'b1, 5'd5, 64'h55, 1'b1, 5'd6, 64'h66);
        tick();
        applyStimulus(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        checkOutput("t6_wren_before", WrEn, 1);
        checkOutput("t6_wraddr_before", WrAddr, 3);
        checkOutput("t6_hazA_before", HazardA, 1);
        checkOutput("t6_mem_ready_before", MemReady, 0);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("t6_wren_async", WrEn, 0);
        checkOutput("t6_wraddr_async", WrAddr, 31);
        checkOutput("t6_mem_ready_rst", MemReady, 1);
        checkOutput("t6_busy_rst", Busy, 0);
        checkOutput("t6_hazA_rst", HazardA, 0);
        tick();
        Reset = 1'b0;
        checkOutput("t6_alu_ready_rel", AluReady, 1);
        checkOutput("t6_busy_rel", Busy, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("t6_no_stale_wren_%0d", k), WrEn, 0);
            checkOutput($sformatf("t6_no_stale_busy_%0d", k), Busy, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
